// File: rtl/aidan_mcnay_counter.sv
// Loadable up-counter with synchronous reset; priority rst > load > increment > hold.
// Define AIDAN_MCNAY_COUNTER_OVERFLOW_EN to add a registered one-cycle wrap flag.
module aidan_mcnay_counter #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [nbits-1:0] in_num,
  input  logic             latch_val,
  input  logic             en,
  output logic [nbits-1:0] out_num
`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  logic [nbits-1:0] count_q;
  logic [nbits-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (latch_val) begin
      count_d = in_num;
    end else if (en) begin
      count_d = count_q + nbits'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_num = count_q;

`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
  logic overflow_q;
  logic overflow_d;

  // Only a real increment from all-ones counts as a wrap; loads never do.
  assign overflow_d = !latch_val && en && (count_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_aidan_mcnay_counter.sv
// Scoreboard bench for aidan_mcnay_counter: 32-bit and 4-bit instances share stimulus.
module tb_aidan_mcnay_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        latch_val = 1'b0;
  logic        en = 1'b0;
  logic [31:0] in_num = '0;
  logic [3:0]  in_num4 = '0;
  logic [31:0] out_num;
  logic [3:0]  out_num4;
`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
  logic        overflow;
  logic        overflow4;
`endif

  always #5 clk = ~clk;

  aidan_mcnay_counter #(.nbits(32)) dut32 (
    .clk      (clk),
    .rst      (rst),
    .in_num   (in_num),
    .latch_val(latch_val),
    .en       (en),
    .out_num  (out_num)
`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  aidan_mcnay_counter #(.nbits(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_num   (in_num4),
    .latch_val(latch_val),
    .en       (en),
    .out_num  (out_num4)
`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
    ,
    .overflow (overflow4)
`endif
  );

  typedef struct {
    logic [31:0] cnt32;
    logic [3:0]  cnt4;
    logic        ovf32;
    logic        ovf4;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model32;
  logic [3:0]  model4;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic l, input logic e, input logic [31:0] d);
    exp_t x;
    rst       = r;
    latch_val = l;
    en        = e;
    in_num    = d;
    in_num4   = d[3:0];
    x.ovf32 = !r && !l && e && (model32 == 32'hFFFF_FFFF);
    x.ovf4  = !r && !l && e && (model4 == 4'hF);
    if (r) begin
      model32 = '0;
      model4  = '0;
    end else if (l) begin
      model32 = d;
      model4  = d[3:0];
    end else if (e) begin
      model32 = model32 + 32'd1;
      model4  = model4 + 4'd1;
    end
    x.cnt32 = model32;
    x.cnt4  = model4;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      x = sb_q.pop_front();
      check("out32", {32'd0, out_num}, {32'd0, x.cnt32});
      check("out4", {60'd0, out_num4}, {60'd0, x.cnt4});
`ifdef AIDAN_MCNAY_COUNTER_OVERFLOW_EN
      check("ovf32", {63'd0, overflow}, {63'd0, x.ovf32});
      check("ovf4", {63'd0, overflow4}, {63'd0, x.ovf4});
`endif
    end
  endtask

  initial begin
    model32 = 'x;
    model4  = 'x;
    repeat (2) @(posedge clk);
    #1;
    // reset wins over a simultaneous load
    step(1'b1, 1'b1, 1'b0, 32'h1234);
    // load then three increments
    step(1'b0, 1'b1, 1'b0, 32'h10);
    repeat (3) step(1'b0, 1'b0, 1'b1, $urandom);
    // load beats enable, then hold while in_num wiggles
    step(1'b0, 1'b1, 1'b1, 32'h5);
    repeat (4) step(1'b0, 1'b0, 1'b0, $urandom);
    // wrap from all-ones, then one quiet cycle
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    // reset mid-count
    step(1'b0, 1'b1, 1'b0, 32'h7);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    // narrow-width wrap path
    step(1'b0, 1'b1, 1'b0, 32'hE);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
    // latch held high reloads every cycle
    step(1'b0, 1'b1, 1'b1, 32'hABCD_0001);
    step(1'b0, 1'b1, 1'b0, 32'h0000_00FF);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
    // random mix, reset rare
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
